// File: rtl/rvv_xrf_wb_merge_if.sv
// rtl/rvv_xrf_wb_merge_if.sv - retire-slot writeback input and async scalar writeback output bundle
interface rvv_xrf_wb_merge_if #(
  parameter int NUM_SLOTS = 4,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
);
  logic [NUM_SLOTS-1:0]             in_valid;
  logic [NUM_SLOTS-1:0][ADDR_W-1:0] in_addr;
  logic [NUM_SLOTS-1:0][DATA_W-1:0] in_data;
  logic [NUM_SLOTS-1:0]             in_ready;
  logic                             out_valid;
  logic [ADDR_W-1:0]                out_addr;
  logic [DATA_W-1:0]                out_data;
  logic                             out_ready;

  // Producer of retire writebacks and consumer of the serialised stream
  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_addr, out_data
  );

  // The merge stage itself
  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/rvv_xrf_wb_merge.sv
// rtl/rvv_xrf_wb_merge.sv - multi-slot scalar writeback merge FIFO (option: RVV_XRF_WB_X0_DROP_EN drops x0 writes)
module rvv_xrf_wb_merge #(
  parameter int NUM_SLOTS = 4,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  rvv_xrf_wb_merge_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     wp_q;
  logic [PW-1:0]     rp_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     free;
  logic [CW-1:0]     store_cnt;
  logic [NUM_SLOTS-1:0] wr_en;
  logic [PW-1:0]     wr_ptr [NUM_SLOTS];
  logic              pop;

  // Ready is a monotone function of free space only, so a lower valid slot
  // can never be refused while a higher one is taken.
  always_comb begin
    free = CW'(DEPTH) - count_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      bus.in_ready[i] = !rst && (free >= CW'(i + 1));
    end
  end

  // Pack the transferring slots, in slot order, into consecutive entries from wp.
  always_comb begin
    store_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      wr_en[i]  = 1'b0;
      wr_ptr[i] = wp_q + store_cnt[PW-1:0];
      if (bus.in_valid[i] && bus.in_ready[i]) begin
`ifdef RVV_XRF_WB_X0_DROP_EN
        if (bus.in_addr[i] != '0) begin
          wr_en[i]  = 1'b1;
          store_cnt = store_cnt + CW'(1);
        end
`else
        wr_en[i]  = 1'b1;
        store_cnt = store_cnt + CW'(1);
`endif
      end
    end
  end

  // Head of queue is presented straight from storage; nothing bypasses the FIFO.
  always_comb begin
    bus.out_valid = (count_q != '0);
    bus.out_addr  = mem_addr[rp_q];
    bus.out_data  = mem_data[rp_q];
    pop           = bus.out_valid && bus.out_ready;
    count         = count_q;
    idle          = (count_q == '0) && (bus.in_valid == '0);
  end

  // Storage, pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_addr[j] <= '0;
        mem_data[j] <= '0;
      end
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en[i]) begin
          mem_addr[wr_ptr[i]] <= bus.in_addr[i];
          mem_data[wr_ptr[i]] <= bus.in_data[i];
        end
      end
      wp_q <= wp_q + store_cnt[PW-1:0];
      if (pop) begin
        rp_q <= rp_q + PW'(1);
      end
      count_q <= count_q + store_cnt - CW'(pop);
    end
  end
endmodule

// File: tb/tb_rvv_xrf_wb_merge.sv
// tb/tb_rvv_xrf_wb_merge.sv - randomized scoreboard bench for rvv_xrf_wb_merge
module tb_rvv_xrf_wb_merge;
  localparam int NS = 4;
  localparam int DEPTH = 8;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] count;
  logic idle;
  int n_vec = 0;
  int n_bad = 0;
  ent_t q[$];

  rvv_xrf_wb_merge_if #(.NUM_SLOTS(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  rvv_xrf_wb_merge #(.NUM_SLOTS(NS), .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .idle  (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every visible output against the scoreboard queue.
  task automatic check_outputs();
    logic [NS-1:0] er;
    int fr;
    fr = DEPTH - q.size();
    for (int i = 0; i < NS; i++) er[i] = !rst && (fr >= i + 1);
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("idle", 64'(idle), 64'((q.size() == 0) && (bus.in_valid == '0)));
    if (q.size() != 0) begin
      chk("out_addr", 64'(bus.out_addr), 64'(q[0].a));
      chk("out_data", 64'(bus.out_data), 64'(q[0].d));
    end
  endtask

  // Apply one cycle of stimulus at the falling edge, check, then advance the model.
  task automatic step(input logic [NS-1:0] v, input logic [NS-1:0][AW-1:0] a,
                      input logic [NS-1:0][DW-1:0] d, input logic ordy);
    int fr;
    bit do_pop;
    bus.in_valid  = v;
    bus.in_addr   = a;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    check_outputs();
    fr = DEPTH - q.size();
    do_pop = (q.size() != 0) && ordy;
    if (do_pop) void'(q.pop_front());
    for (int i = 0; i < NS; i++) begin
      if (v[i] && (fr >= i + 1)) begin
`ifdef RVV_XRF_WB_X0_DROP_EN
        if (a[i] != 0) q.push_back('{a: a[i], d: d[i]});
`else
        q.push_back('{a: a[i], d: d[i]});
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_step(input logic ordy);
    step('0, '0, '0, ordy);
  endtask

  initial begin
    logic [NS-1:0][AW-1:0] a;
    logic [NS-1:0][DW-1:0] d;
    logic [NS-1:0] v;

    bus.in_valid  = '0;
    bus.in_addr   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_addr", 64'(bus.out_addr), 64'h0);
    chk("rst_out_data", 64'(bus.out_data), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_idle", 64'(idle), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    // Single push, then pop.
    a = '0; d = '0; a[0] = 5'd3; d[0] = 32'hAA;
    step(4'b0001, a, d, 1'b1);
    chk("t1_addr", 64'(bus.out_addr), 64'd3);
    chk("t1_data", 64'(bus.out_data), 64'hAA);
    idle_step(1'b1);
    chk("t1_idle", 64'(idle), 64'h1);

    // Sparse slots keep slot order.
    a = '0; d = '0;
    a[0] = 5'd1; a[1] = 5'd2; a[3] = 5'd4;
    d[0] = 32'h11; d[1] = 32'h22; d[3] = 32'h44;
    step(4'b1011, a, d, 1'b0);
    chk("t2_count", 64'(count), 64'd3);
    repeat (3) idle_step(1'b1);
    idle_step(1'b1);

    // Fill to full, then one pop frees exactly one slot.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NS; i++) begin
        a[i] = AW'(k * 4 + i + 1);
        d[i] = $urandom;
      end
      step(4'b1111, a, d, 1'b0);
    end
    chk("t3_full_rdy", 64'(bus.in_ready), 64'h0);
    idle_step(1'b1);
    chk("t3_one_rdy", 64'(bus.in_ready), 64'h1);

    // count==7 with simultaneous pop: only slot 0 goes in; slot 1 stays pending.
    a[0] = 5'd20; a[1] = 5'd21; d[0] = 32'h200; d[1] = 32'h210;
    step(4'b0011, a, d, 1'b1);
    chk("t4_count", 64'(count), 64'd7);
    step(4'b0010, a, d, 1'b1);
    repeat (9) idle_step(1'b1);
    chk("t4_drained", 64'(count), 64'd0);

    // x0 handling.
    a = '0; d = '0; a[0] = 5'd0; a[1] = 5'd5; d[0] = 32'hF0; d[1] = 32'hF5;
    step(4'b0011, a, d, 1'b0);
`ifdef RVV_XRF_WB_X0_DROP_EN
    chk("t6_count", 64'(count), 64'd1);
    chk("t6_addr", 64'(bus.out_addr), 64'd5);
`else
    chk("t6_count", 64'(count), 64'd2);
    chk("t6_addr", 64'(bus.out_addr), 64'd0);
`endif
    repeat (3) idle_step(1'b1);

    // Wrap: single pushes/pops with random stalls.
    for (int k = 0; k < 40; k++) begin
      a = '0; d = '0;
      a[0] = AW'($urandom_range(1, 31));
      d[0] = $urandom;
      step(4'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 2) != 0));
    end

    // Random multi-slot traffic with one asynchronous reset in the middle.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NS; i++) begin
        a[i] = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
        d[i] = $urandom;
      end
      v = NS'($urandom);
      step(v, a, d, 1'($urandom_range(0, 3) != 0));
      if (k == 200) begin
        #2 rst = 1'b1;
        #1;
        q.delete();
        chk("mid_rst_count", 64'(count), 64'h0);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'h0);
        chk("mid_rst_rdy", 64'(bus.in_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rdy", 64'(bus.in_ready), 64'hF);
      end
    end

    repeat (12) idle_step(1'b1);
    chk("final_count", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
